// File: rtl/bcd_mod_counter_pkg.sv
// bcd_mod_counter_pkg
//   Shared BCD constants, types and helpers for the bcd_mod_counter slice.
//   - BCD_DIGIT_W / BCD_MAX_DIGIT : digit width and largest legal digit
//   - bcd_digit_t / bcd_vec_t     : one digit, and the widest supported vector (4 digits)
//   - bcd_op_e                    : per-edge action chosen by the counter
//   - int_to_bcd                  : constant function, integer -> BCD vector
//   - bcd_digits_ok               : true when every used digit is 0..9
package bcd_mod_counter_pkg;

  localparam int unsigned BCD_DIGIT_W    = 4;
  localparam int unsigned BCD_MAX_DIGITS = 4;
  localparam logic [3:0]  BCD_MAX_DIGIT  = 4'd9;

  typedef logic [BCD_DIGIT_W-1:0]                bcd_digit_t;
  typedef logic [BCD_MAX_DIGITS*BCD_DIGIT_W-1:0] bcd_vec_t;

  typedef enum logic [2:0] {
    OP_HOLD,
    OP_CLEAR,
    OP_LOAD,
    OP_UP,
    OP_DOWN
  } bcd_op_e;

  function automatic bcd_vec_t int_to_bcd(input int unsigned value);
    bcd_vec_t    r;
    int unsigned v;
    r = '0;
    v = value;
    for (int unsigned i = 0; i < BCD_MAX_DIGITS; i++) begin
      r[BCD_DIGIT_W*i +: BCD_DIGIT_W] = 4'(v % 10);
      v = v / 10;
    end
    return r;
  endfunction

  function automatic logic bcd_digits_ok(input bcd_vec_t v, input int unsigned digits);
    logic ok;
    ok = 1'b1;
    for (int unsigned i = 0; i < BCD_MAX_DIGITS; i++) begin
      if (i < digits && v[BCD_DIGIT_W*i +: BCD_DIGIT_W] > BCD_MAX_DIGIT) ok = 1'b0;
    end
    return ok;
  endfunction

endpackage

// File: rtl/bcd_mod_counter_digit_cell.sv
// bcd_digit_cell
//   One BCD digit stepping up or down by cin, with carry/borrow out.
//   Purely combinational; the parent applies the modulus wrap.
//   Ports:
//     digit_in  - current digit value
//     up_dn     - 1 = increment, 0 = decrement
//     cin       - carry (up) / borrow (down) into this digit
//     digit_out - stepped digit
//     cout      - carry/borrow into the next more significant digit
module bcd_digit_cell
  import bcd_mod_counter_pkg::*;
(
  input  bcd_digit_t digit_in,
  input  logic       up_dn,
  input  logic       cin,
  output bcd_digit_t digit_out,
  output logic       cout
);

  always_comb begin
    digit_out = digit_in;
    cout      = 1'b0;
    if (cin) begin
      if (up_dn) begin
        // Illegal digits (>9) roll like 9; the parent zeroes such values anyway.
        if (digit_in >= BCD_MAX_DIGIT) begin
          digit_out = '0;
          cout      = 1'b1;
        end else begin
          digit_out = digit_in + 4'd1;
        end
      end else begin
        if (digit_in == '0) begin
          digit_out = BCD_MAX_DIGIT;
          cout      = 1'b1;
        end else begin
          digit_out = digit_in - 4'd1;
        end
      end
    end
  end

endmodule

// File: rtl/bcd_mod_counter.sv
// bcd_mod_counter
//   Parametrised multi-digit BCD modulo counter (0..MODULUS-1), up/down,
//   with synchronous clear and parallel load. Stages chain via tc -> en.
//   Parameters: DIGITS (1..4), MODULUS (2..10**DIGITS).
//   Ports:
//     clk      - rising-edge clock
//     reset    - asynchronous active-low reset
//     clear    - synchronous clear (highest priority)
//     load     - synchronous parallel load of load_val
//     en       - count tick / carry-in from previous stage
//     up_dn    - 1 = count up, 0 = count down
//     load_val - BCD value to load, digit 0 in [3:0]
//     count    - current BCD value
//     tc       - combinational terminal count (carry/borrow out)
//     load_err - one-cycle flag for a rejected load
//                (only with BCD_MOD_COUNTER_LOAD_CHECK_EN defined)
//   Build option: BCD_MOD_COUNTER_LOAD_CHECK_EN rejects loads with a digit > 9
//   or a value >= MODULUS instead of taking load_val verbatim.
module bcd_mod_counter
  import bcd_mod_counter_pkg::*;
#(
  parameter int unsigned DIGITS  = 2,
  parameter int unsigned MODULUS = 60
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          clear,
  input  logic                          en,
  input  logic                          up_dn,
  input  logic                          load,
  input  logic [BCD_DIGIT_W*DIGITS-1:0] load_val,
  output logic [BCD_DIGIT_W*DIGITS-1:0] count,
  output logic                          tc
`ifdef BCD_MOD_COUNTER_LOAD_CHECK_EN
  ,
  output logic                          load_err
`endif
);

  localparam int unsigned W        = BCD_DIGIT_W * DIGITS;
  localparam bcd_vec_t    MAX_FULL = int_to_bcd(MODULUS - 1);
  localparam logic [W-1:0] MAX_BCD = MAX_FULL[W-1:0];

  logic [W-1:0]    count_q, count_d;
  logic [W-1:0]    step_val;
  logic [DIGITS:0] chain;
  logic            count_ok;
  logic            is_max;
  logic            is_zero;
  bcd_op_e         op;

  assign chain[0] = 1'b1;

  for (genvar g = 0; g < DIGITS; g++) begin : g_digit
    bcd_digit_cell u_cell (
      .digit_in  (count_q[BCD_DIGIT_W*g +: BCD_DIGIT_W]),
      .up_dn     (up_dn),
      .cin       (chain[g]),
      .digit_out (step_val[BCD_DIGIT_W*g +: BCD_DIGIT_W]),
      .cout      (chain[g+1])
    );
  end

  // With all digits legal, plain unsigned compare of the BCD vector orders
  // values numerically.
  always_comb begin
    count_ok = bcd_digits_ok(bcd_vec_t'(count_q), DIGITS) && (count_q <= MAX_BCD);
    is_max   = (count_q == MAX_BCD);
    is_zero  = (count_q == '0);

    op = OP_HOLD;
    if (clear)     op = OP_CLEAR;
    else if (load) op = OP_LOAD;
    else if (en)   op = up_dn ? OP_UP : OP_DOWN;
  end

  assign tc = en & ~clear & ~load & (up_dn ? is_max : is_zero);

`ifdef BCD_MOD_COUNTER_LOAD_CHECK_EN
  logic load_ok;
  logic load_err_q, load_err_d;

  always_comb begin
    load_ok    = bcd_digits_ok(bcd_vec_t'(load_val), DIGITS) && (load_val <= MAX_BCD);
    load_err_d = (op == OP_LOAD) && !load_ok;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) load_err_q <= 1'b0;
    else        load_err_q <= load_err_d;
  end

  assign load_err = load_err_q;
`endif

  always_comb begin
    count_d = count_q;
    unique case (op)
      OP_CLEAR: count_d = '0;
`ifdef BCD_MOD_COUNTER_LOAD_CHECK_EN
      OP_LOAD:  if (load_ok) count_d = load_val;
`else
      OP_LOAD:  count_d = load_val;
`endif
      OP_UP:    count_d = (!count_ok || is_max) ? '0 : step_val;
      // A borrow out of the top digit means every digit was zero.
      OP_DOWN:  count_d = (!count_ok || chain[DIGITS]) ? MAX_BCD : step_val;
      default:  count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) count_q <= '0;
    else        count_q <= count_d;
  end

  assign count = count_q;

endmodule

// File: tb/tb_bcd_mod_counter.sv
module tb_bcd_mod_counter;

  localparam int M = 60;

  logic       clk = 1'b0;
  logic       reset;
  logic       clear, load, en, up_dn;
  logic [7:0] load_val;
  logic [7:0] count;
  logic       tc;

  // chained minutes (60) -> hours (24) stages
  logic       ch_load, ch_up, min_en;
  logic [7:0] min_lv, hr_lv, min_cnt, hr_cnt;
  logic       min_tc, hr_tc;

`ifdef BCD_MOD_COUNTER_LOAD_CHECK_EN
  logic load_err, min_err, hr_err;
`endif

  always #5 clk = ~clk;

  bcd_mod_counter #(.DIGITS(2), .MODULUS(60)) u_dut (
    .clk(clk), .reset(reset), .clear(clear), .en(en), .up_dn(up_dn),
    .load(load), .load_val(load_val), .count(count), .tc(tc)
`ifdef BCD_MOD_COUNTER_LOAD_CHECK_EN
    , .load_err(load_err)
`endif
  );

  bcd_mod_counter #(.DIGITS(2), .MODULUS(60)) u_min (
    .clk(clk), .reset(reset), .clear(1'b0), .en(min_en), .up_dn(ch_up),
    .load(ch_load), .load_val(min_lv), .count(min_cnt), .tc(min_tc)
`ifdef BCD_MOD_COUNTER_LOAD_CHECK_EN
    , .load_err(min_err)
`endif
  );

  bcd_mod_counter #(.DIGITS(2), .MODULUS(24)) u_hr (
    .clk(clk), .reset(reset), .clear(1'b0), .en(min_tc), .up_dn(ch_up),
    .load(ch_load), .load_val(hr_lv), .count(hr_cnt), .tc(hr_tc)
`ifdef BCD_MOD_COUNTER_LOAD_CHECK_EN
    , .load_err(hr_err)
`endif
  );

  typedef struct {
    logic       tc;
    logic [7:0] cnt;
    logic       err;
  } exp_t;

  exp_t       sb_q[$];
  int         n_checks = 0;
  int         n_fail   = 0;
  int         pending  = 0;
  int         tc_seen  = 0;
  logic [7:0] m_raw    = 8'h00;

  function automatic int bcd2int(input logic [7:0] v);
    return 10 * int'(v[7:4]) + int'(v[3:0]);
  endfunction

  function automatic logic [7:0] int2bcd(input int n);
    logic [7:0] r;
    r[7:4] = 4'(n / 10);
    r[3:0] = 4'(n % 10);
    return r;
  endfunction

  function automatic bit in_range(input logic [7:0] v);
    return (v[7:4] <= 4'd9) && (v[3:0] <= 4'd9) && (bcd2int(v) < M);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Drive one cycle of inputs and queue the reference response.
  task automatic step(input logic c, input logic l, input logic e, input logic u,
                      input logic [7:0] lv);
    exp_t x;
    @(negedge clk);
    clear = c; load = l; en = e; up_dn = u; load_val = lv;
    x.tc  = e && !c && !l && (u ? (m_raw == int2bcd(M - 1)) : (m_raw == 8'h00));
    x.err = 1'b0;
    if (c) begin
      m_raw = 8'h00;
    end else if (l) begin
`ifdef BCD_MOD_COUNTER_LOAD_CHECK_EN
      if (in_range(lv)) m_raw = lv;
      else              x.err = 1'b1;
`else
      m_raw = lv;
`endif
    end else if (e) begin
      if (u) m_raw = in_range(m_raw) ? int2bcd((bcd2int(m_raw) + 1) % M) : 8'h00;
      else   m_raw = in_range(m_raw) ? int2bcd((bcd2int(m_raw) + M - 1) % M) : int2bcd(M - 1);
    end
    x.cnt = m_raw;
    sb_q.push_back(x);
    pending++;
  endtask

  task automatic drain();
    step(1'b0, 1'b0, 1'b0, 1'b1, 8'h00);
    for (int i = 0; i < 20 && pending != 0; i++) @(negedge clk);
    if (pending != 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL drain_timeout: got %0d pending expected 0", pending);
    end
  endtask

  // Monitor: tc is checked mid-cycle, count one edge later.
  initial begin : monitor
    exp_t x;
    forever begin
      @(negedge clk);
      #2;
      if (sb_q.size() > 0) begin
        x = sb_q.pop_front();
        if (tc) tc_seen++;
        check("tc", tc, x.tc);
        @(posedge clk);
        #1;
        check("count", count, x.cnt);
`ifdef BCD_MOD_COUNTER_LOAD_CHECK_EN
        check("load_err", load_err, x.err);
`endif
        pending--;
      end
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin : stim
    int base;
    reset = 1'b0; clear = 1'b0; load = 1'b0; en = 1'b0; up_dn = 1'b1; load_val = 8'h00;
    ch_load = 1'b0; ch_up = 1'b1; min_en = 1'b0; min_lv = 8'h00; hr_lv = 8'h00;
    #3;
    check("reset_count", count, 8'h00);
    #4 reset = 1'b1;

    // Asynchronous reset mid-count
    step(1'b0, 1'b1, 1'b0, 1'b1, 8'h37);
    drain();
    check("preload_37", count, 8'h37);
    @(negedge clk);
    #2 reset = 1'b0;
    #1;
    check("async_reset_count", count, 8'h00);
`ifdef BCD_MOD_COUNTER_LOAD_CHECK_EN
    check("async_reset_err", load_err, 1'b0);
`endif
    m_raw = 8'h00;
    #1 reset = 1'b1;
    repeat (3) step(1'b0, 1'b0, 1'b1, 1'b1, 8'h00);
    drain();
    check("after_3_en", count, 8'h03);

    // Up wrap 58 -> 59 -> 00
    step(1'b0, 1'b1, 1'b0, 1'b1, 8'h58);
    step(1'b0, 1'b0, 1'b1, 1'b1, 8'h00);
    step(1'b0, 1'b0, 1'b1, 1'b1, 8'h00);
    drain();
    check("wrap_to_00", count, 8'h00);

    // Full revolution: one tc pulse
    base = tc_seen;
    repeat (M) step(1'b0, 1'b0, 1'b1, 1'b1, 8'h00);
    drain();
    check("rev_count", count, 8'h00);
    check("rev_tc_pulses", tc_seen - base, 1);

    // Down and borrow
    step(1'b0, 1'b1, 1'b0, 1'b0, 8'h10);
    step(1'b0, 1'b0, 1'b1, 1'b0, 8'h00);
    drain();
    check("down_10_to_09", count, 8'h09);
    step(1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
    step(1'b0, 1'b0, 1'b1, 1'b0, 8'h00);
    drain();
    check("down_00_to_59", count, 8'h59);

    // Priority
    step(1'b1, 1'b1, 1'b1, 1'b1, 8'h25);
    step(1'b0, 1'b1, 1'b1, 1'b1, 8'h25);
    drain();
    check("load_over_en", count, 8'h25);

    // Illegal loads: rejected with load check, otherwise taken and wrapped
    step(1'b0, 1'b1, 1'b0, 1'b1, 8'h6A);
    step(1'b0, 1'b0, 1'b0, 1'b1, 8'h00);
    step(1'b0, 1'b1, 1'b0, 1'b1, 8'h60);
    step(1'b0, 1'b0, 1'b1, 1'b1, 8'h00);
    step(1'b0, 1'b1, 1'b0, 1'b0, 8'h9F);
    step(1'b0, 1'b0, 1'b1, 1'b0, 8'h00);
    step(1'b1, 1'b1, 1'b0, 1'b1, 8'hFF);
    drain();

    // Randomized traffic
    for (int i = 0; i < 300; i++) begin
      int r;
      logic [7:0] lv;
      r  = $urandom_range(0, 15);
      lv = ($urandom_range(0, 1) == 1) ? int2bcd($urandom_range(0, M - 1)) : 8'($urandom);
      step(r == 0, (r == 1) || (r == 2), $urandom_range(0, 3) != 0,
           1'($urandom_range(0, 1)), lv);
    end
    drain();

    // Chained hours:minutes, 23:59 -> 00:00 on one edge
    @(negedge clk);
    ch_load = 1'b1; min_lv = 8'h59; hr_lv = 8'h23;
    @(negedge clk);
    ch_load = 1'b0; min_en = 1'b1;
    #2;
    check("chain_min_pre", min_cnt, 8'h59);
    check("chain_hr_pre", hr_cnt, 8'h23);
    check("chain_min_tc", min_tc, 1'b1);
    check("chain_hr_tc", hr_tc, 1'b1);
    @(posedge clk);
    #1;
    check("chain_min_post", min_cnt, 8'h00);
    check("chain_hr_post", hr_cnt, 8'h00);
    @(negedge clk);
    min_en = 1'b0;
    #2;
    check("chain_hr_tc_low", hr_tc, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
